// File: rtl/ps2_host_tx_pkg.sv
// ============================================================
// ps2_pkg: shared PS/2 types, error codes and command bytes. Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAIL      = 3'd7
  } tx_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NOACK   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
// ============================================================
// ps2_host_tx_if: command request / status bundle. Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, error, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, error, err_code
  );
endinterface

`default_nettype wire

// File: rtl/ps2_host_tx_sync_edge.sv
// ============================================================
// ps2_sync_edge: 3-flop line synchronizers and ps2_clk fall pulse. Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [2:0] clk_sr;
  logic [2:0] data_sr;

  // Reset to the idle-high line level so no spurious fall follows reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sr  <= 3'b111;
      data_sr <= 3'b111;
    end else begin
      clk_sr  <= {clk_sr[1:0], ps2_clk};
      data_sr <= {data_sr[1:0], ps2_data};
    end
  end

  assign clk_sync  = clk_sr[2];
  assign data_sync = data_sr[2];
  assign clk_fall  = clk_sr[2] & ~clk_sr[1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================
// ps2_host_tx: open-drain host-to-device PS/2 command transmitter. Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         clrn,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         ps2_clk_drive_low,
  output logic         ps2_data_drive_low
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       frame;
  logic             bit_low;
  logic [1:0]       err_code;
  logic [1:0]       err_next;
  logic             clk_s;
  logic             data_s;
  logic             clk_fall;
  logic             accept;
  logic             timeout;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic             error_o;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_sync  (clk_s),
    .data_sync (data_s),
    .clk_fall  (clk_fall)
  );

  assign accept  = (state == ST_IDLE) && tx.tx_valid;
  assign timeout = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Timeout is tested first in every watched state so it beats a coincident fall.
  always_comb begin
    state_next = state;
    err_next   = err_code;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_INHIBIT;
          err_next   = ERR_NONE;
        end
      end
      ST_INHIBIT: if (inh_cnt == INH_LAST) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (timeout) begin
          state_next = ST_FAIL;
          err_next   = ERR_TIMEOUT;
        end else if (clk_fall && bit_cnt == 4'd9) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (timeout) begin
          state_next = ST_FAIL;
          err_next   = ERR_TIMEOUT;
        end else if (clk_fall) begin
          if (data_s) begin
            state_next = ST_FAIL;
            err_next   = ERR_NOACK;
          end else begin
            state_next = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (timeout) begin
          state_next = ST_FAIL;
          err_next   = ERR_TIMEOUT;
        end else if (clk_s && data_s) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_FAIL: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Drives decode straight from state so an async reset releases the lines at once.
  always_comb begin
    ready_o            = 1'b0;
    busy_o             = 1'b0;
    done_o             = 1'b0;
    error_o            = 1'b0;
    ps2_clk_drive_low  = 1'b0;
    ps2_data_drive_low = 1'b0;
    case (state)
      ST_IDLE:      ready_o = 1'b1;
      ST_INHIBIT: begin
        busy_o            = 1'b1;
        ps2_clk_drive_low = 1'b1;
      end
      ST_RELEASE: begin
        busy_o             = 1'b1;
        ps2_clk_drive_low  = 1'b1;
        ps2_data_drive_low = 1'b1;
      end
      ST_SHIFT: begin
        busy_o             = 1'b1;
        ps2_data_drive_low = bit_low;
      end
      ST_ACK:       busy_o  = 1'b1;
      ST_WAIT_IDLE: busy_o  = 1'b1;
      ST_DONE:      done_o  = 1'b1;
      ST_FAIL:      error_o = 1'b1;
      default:      ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inh_cnt  <= '0;
      tmo_cnt  <= '0;
      bit_cnt  <= 4'd0;
      frame    <= 10'd0;
      bit_low  <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      err_code <= err_next;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            frame   <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
            inh_cnt <= '0;
          end
        end
        ST_INHIBIT: inh_cnt <= inh_cnt + INH_W'(1);
        ST_RELEASE: begin
          bit_cnt <= 4'd0;
          tmo_cnt <= '0;
          bit_low <= 1'b1;
        end
        ST_SHIFT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (clk_fall) begin
            bit_low <= ~frame[0];
            frame   <= {1'b1, frame[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_ACK:       tmo_cnt <= tmo_cnt + TMO_W'(1);
        ST_WAIT_IDLE: tmo_cnt <= tmo_cnt + TMO_W'(1);
        default:      tmo_cnt <= tmo_cnt;
      endcase
    end
  end

  assign tx.tx_ready = ready_o;
  assign tx.busy     = busy_o;
  assign tx.done     = done_o;
  assign tx.error    = error_o;
  assign tx.err_code = err_code;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================
// tb_ps2_host_tx: directed bench with a PS/2 device model. Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 10;
  localparam int TMO = 2000;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if tx_if();

  logic clk_dl;
  logic data_dl;
  logic dev_clk_low;
  logic dev_data_low;
  logic ps2_clk_line;
  logic ps2_data_line;
  assign ps2_clk_line  = ~(clk_dl | dev_clk_low);
  assign ps2_data_line = ~(data_dl | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                (clk),
    .clrn               (clrn),
    .tx                 (tx_if),
    .ps2_clk            (ps2_clk_line),
    .ps2_data           (ps2_data_line),
    .ps2_clk_drive_low  (clk_dl),
    .ps2_data_drive_low (data_dl)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int done_cnt = 0;
  int err_cnt  = 0;
  always @(negedge clk) begin
    if (tx_if.done)  done_cnt++;
    if (tx_if.error) err_cnt++;
  end

  // Device model: 0 = acks, 1 = withholds ack, 2 = never clocks.
  int          bfm_mode   = 0;
  bit          bfm_abort  = 1'b0;
  bit          bfm_busy   = 1'b0;
  int          bfm_frames = 0;
  int          bfm_nbits  = 0;
  logic [10:0] bfm_bits   = '0;

  initial begin : bfm
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      @(negedge clk);
      if (bfm_mode != 2 && clrn && !clk_dl && data_dl) begin
        bfm_busy    = 1'b1;
        bfm_frames++;
        bfm_bits    = '0;
        bfm_bits[0] = ps2_data_line;
        bfm_nbits   = 1;
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
          if (bfm_abort) break;
          if (i == 11) begin
            if (bfm_mode == 0) dev_data_low = 1'b1;
            repeat (10) @(negedge clk);
          end
          dev_clk_low = 1'b1;
          repeat (20) @(negedge clk);
          dev_clk_low = 1'b0;
          if (i <= 10) begin
            bfm_bits[i] = ps2_data_line;
            bfm_nbits   = i + 1;
          end
          repeat (20) @(negedge clk);
        end
        dev_data_low = 1'b0;
        dev_clk_low  = 1'b0;
        bfm_busy     = 1'b0;
      end
    end
  end

  typedef struct {
    logic [7:0]  data;
    int          mode;
    bit          poke;
    logic [10:0] bits;   // {stop, parity, d7..d0, start}
    int          n_done;
    int          n_err;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[5];

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v);
    int d0;
    int e0;
    int f0;
    int n;
    d0 = done_cnt;
    e0 = err_cnt;
    f0 = bfm_frames;
    bfm_mode = v.mode;
    send(v.data);
    if (v.poke) begin
      repeat (100) @(negedge clk);
      check("ready_mid", tx_if.tx_ready, 0);
      tx_if.tx_data  = 8'hAA;
      tx_if.tx_valid = 1'b1;
      repeat (3) @(negedge clk);
      tx_if.tx_valid = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("end_%h", v.data), n < 6000, 1);
    n = 0;
    while (bfm_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (60) @(negedge clk);
    check($sformatf("bits_%h", v.data), bfm_bits, v.bits);
    check($sformatf("frames_%h", v.data), bfm_frames - f0, 1);
    check($sformatf("done_%h", v.data), done_cnt - d0, v.n_done);
    check($sformatf("err_%h", v.data), err_cnt - e0, v.n_err);
    check($sformatf("code_%h", v.data), tx_if.err_code, v.code);
    check($sformatf("ready_%h", v.data), tx_if.tx_ready, 1);
    check($sformatf("busy_%h", v.data), tx_if.busy, 0);
    check($sformatf("cdl_%h", v.data), clk_dl, 0);
    check($sformatf("ddl_%h", v.data), data_dl, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int d0;
    int e0;
    vec_t v;

    vecs[0] = '{CMD_SET_LEDS, 0, 1'b0, 11'b111_1101_1010, 1, 0, 2'd0};
    vecs[1] = '{8'h07,        0, 1'b1, 11'b100_0000_1110, 1, 0, 2'd0};
    vecs[2] = '{8'h00,        0, 1'b0, 11'b110_0000_0000, 1, 0, 2'd0};
    vecs[3] = '{8'hAA,        1, 1'b0, 11'b111_0101_0100, 0, 1, 2'd1};
    vecs[4] = '{CMD_ECHO,     0, 1'b0, 11'b111_1101_1100, 1, 0, 2'd0};

    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;

    #2 clrn = 1'b0;
    #1;
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_busy", tx_if.busy, 0);
    check("rst_done", tx_if.done, 0);
    check("rst_error", tx_if.error, 0);
    check("rst_code", tx_if.err_code, 0);
    check("rst_cdl", clk_dl, 0);
    check("rst_ddl", data_dl, 0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 5; k++) run_xfer(vecs[k]);

    // Inhibit window: clk low alone, then one cycle with both low, then clk released.
    bfm_mode = 0;
    d0 = done_cnt;
    @(negedge clk);
    tx_if.tx_data  = 8'h3C;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    n = 0;
    while (clk_dl && !data_dl && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    n = 0;
    while (clk_dl && data_dl && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("overlap_len", n, 1);
    check("released_cdl", clk_dl, 0);
    check("start_ddl", data_dl, 1);
    n = 0;
    while (done_cnt == d0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_done", done_cnt - d0, 1);
    while (bfm_busy) @(negedge clk);
    repeat (60) @(negedge clk);

    // Silent device: timeout after TMO cycles of released clock.
    bfm_mode = 2;
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h55);
    n = 0;
    while (!data_dl && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (clk_dl && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_if.error && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_code", tx_if.err_code, 2);
    check("tmo_cdl", clk_dl, 0);
    check("tmo_ddl", data_dl, 0);
    @(negedge clk);
    check("tmo_pulse", tx_if.error, 0);
    check("tmo_errcnt", err_cnt - e0, 1);
    check("tmo_done", done_cnt - d0, 0);
    check("tmo_ready", tx_if.tx_ready, 1);
    repeat (10) @(negedge clk);

    // Async reset after the 4th data bit, then a clean 0xFF transfer.
    bfm_mode  = 0;
    bfm_nbits = 0;
    send(8'hF0);
    n = 0;
    while (bfm_nbits < 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("pre_rst_ddl", data_dl, 1);
    check("pre_rst_busy", tx_if.busy, 1);
    clrn = 1'b0;
    #1;
    check("mid_rst_cdl", clk_dl, 0);
    check("mid_rst_ddl", data_dl, 0);
    check("mid_rst_busy", tx_if.busy, 0);
    check("mid_rst_ready", tx_if.tx_ready, 1);
    check("mid_rst_code", tx_if.err_code, 0);
    repeat (2) @(negedge clk);
    clrn      = 1'b1;
    bfm_abort = 1'b1;
    n = 0;
    while (bfm_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    bfm_abort = 1'b0;
    repeat (10) @(negedge clk);
    v = '{CMD_RESET, 0, 1'b0, 11'b111_1111_1110, 1, 0, 2'd0};
    run_xfer(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
